// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch stage:
//   INSTR_W      instruction / address width
//   NOP_INSTR    encoding used for pipeline bubbles
//   fetch_state_e  fetch FSM states {IDLE, FETCH, DRAIN, HOLD}
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // only after reset
        FETCH = 2'd1,   // request outstanding for pc
        DRAIN = 2'd2,   // request outstanding for a stale address, data dropped
        HOLD  = 2'd3    // no request, skid buffer holds a fetched instruction
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {instruction, pc} register that catches an instruction returning
// from memory while the pipeline is frozen.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture d_instr/d_pc and mark full
//   clear             empty the entry (wins over load)
//   d_instr, d_pc     data to capture
//   full              entry holds a valid instruction
//   q_instr, q_pc     stored data
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [INSTR_W-1:0] d_pc,
    output logic               full,
    output logic [INSTR_W-1:0] q_instr,
    output logic [INSTR_W-1:0] q_pc
);

    logic               full_q,  full_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_q,    pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            full_d  = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = '0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = d_instr;
            pc_d    = d_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full    = full_q;
    assign q_instr = instr_q;
    assign q_pc    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory
// port and holds the IF/ID register consumed by decode. Redirects on taken
// branches, inserts NOP bubbles, stalls on freeze and uses a one-entry skid
// buffer for an instruction that returns while frozen.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   freeze                    hazard stall (also masks br_taken)
//   br_taken, br_offset       taken branch in decode, sign-extended word offset
//   id_pc                     PC+4 of the instruction in decode
//   imem_req, imem_addr       fetch request / byte address (registered state)
//   imem_ack, imem_rdata      accept + same-cycle read data
//   valid, instruction, pc_out  IF/ID register
// Optional (FETCH_PERF_CNT_EN defined):
//   stall_cnt                 cycles with freeze or an unacknowledged request
//   flush_cnt                 accepted branches
// -----------------------------------------------------------------------------
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               br_taken,
    input  logic [INSTR_W-1:0] br_offset,
    input  logic [INSTR_W-1:0] id_pc,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] drain_addr_q, drain_addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_out_q, pc_out_d;

    logic               skid_load, skid_clear, skid_full;
    logic [INSTR_W-1:0] skid_instr, skid_pc;

    logic [INSTR_W-1:0] pc_plus4;
    logic [INSTR_W-1:0] br_target;
    logic               br_accept;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = id_pc + (br_offset << 2);
    // Frozen branches are ignored; decode re-presents them after the freeze.
    assign br_accept = br_taken && !freeze && (state_q != IDLE);
    assign skid_clear = br_accept || (state_q == HOLD && !freeze);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        skid_load    = 1'b0;

        // Bubble: valid and instruction cleared, pc_out left as it was.
        if (br_accept) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = br_target;
        end

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                if (br_accept) begin
                    // Unacked request must complete at its old address first.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (freeze) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        valid_d  = 1'b1;
                        instr_d  = imem_rdata;
                        pc_out_d = pc_plus4;
                    end
                end else if (!freeze) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end

            DRAIN: begin
                if (!freeze) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
                // A re-target while draining only moves pc; the stale request
                // still has to be acknowledged before fetching the target.
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (br_accept) begin
                    state_d = FETCH;
                end else if (!freeze && skid_full) begin
                    valid_d  = 1'b1;
                    instr_d  = skid_instr;
                    pc_out_d = skid_pc;
                    state_d  = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_instr (imem_rdata),
        .d_pc    (pc_plus4),
        .full    (skid_full),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
    );

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign valid       = valid_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze || (imem_req && !imem_ack)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (br_accept) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Cycle-table bench for if_fetch_unit (RESET_PC = 0x40). Each row gives the
// inputs driven in one cycle and the registered outputs expected in that same
// cycle; a few hand-written sequences follow for multi-cycle corners.
// Counter outputs are checked only when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_offset = '0;
    logic [31:0] id_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h40)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .id_pc       (id_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .instruction (instruction),
        .pc_out      (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        frz;
        logic        br;
        logic [31:0] off;
        logic [31:0] idpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pco;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, f, b, input logic [31:0] o, ip,
                                input logic a, input logic [31:0] d,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, ep,
                                input string nm);
        vec_t v;
        v.rst_n = r;  v.frz = f;  v.br = b;  v.off = o;  v.idpc = ip;
        v.ack = a;    v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pco = ep;
        v.name = nm;
        return v;
    endfunction

    task automatic drive(input logic r, f, b, input logic [31:0] o, ip,
                         input logic a, input logic [31:0] d);
        rst = r; freeze = f; br_taken = b; br_offset = o; id_pc = ip;
        imem_ack = a; imem_rdata = d;
    endtask

    task automatic check(input string nm, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        n_vec++;
        if (imem_req !== er || imem_addr !== ea || valid !== ev ||
            instruction !== ei || pc_out !== ep) begin
            n_err++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc_out=%h, want req=%0b addr=%h valid=%0b instr=%h pc_out=%h",
                     nm, imem_req, imem_addr, valid, instruction, pc_out, er, ea, ev, ei, ep);
        end else begin
            $display("ok   %s: req=%0b addr=%h valid=%0b instr=%h pc_out=%h",
                     nm, imem_req, imem_addr, valid, instruction, pc_out);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        //              rst f b off           idpc    ack rdata         req addr          v instr         pc_out
        vecs.push_back(mk(0,0,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h40,       0, 32'h0,        32'h0,  "reset"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h40,       0, 32'h0,        32'h0,  "idle"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h40,       1, 32'h40,       0, 32'h0,        32'h0,  "first_req"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h44,       1, 32'h44,       1, 32'h40,       32'h44, "stream1"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h48,       1, 32'h48,       1, 32'h44,       32'h48, "stream2"));
        vecs.push_back(mk(1,0,1,32'h2,       32'h0,  1, 32'h4C,       1, 32'h4C,       1, 32'h48,       32'h4C, "br_ack"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h4C, "wait1"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h4C, "wait2"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h1111_0008,1, 32'h8,        0, 32'h0,        32'h4C, "late_ack"));
        vecs.push_back(mk(1,0,1,32'hFFFF_FFFE,32'h20,0, 32'h0,        1, 32'hC,        1, 32'h1111_0008,32'hC,  "br_noack"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'hC,        0, 32'h0,        32'hC,  "drain"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'hBAD0_000C,1, 32'hC,        0, 32'h0,        32'hC,  "drain_ack"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h18,       1, 32'h18,       0, 32'h0,        32'hC,  "target"));
        vecs.push_back(mk(1,1,0,32'h0,       32'h0,  1, 32'hDEAD_BEEF,1, 32'h1C,       1, 32'h18,       32'h1C, "frz_ack"));
        vecs.push_back(mk(1,1,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h20,       1, 32'h18,       32'h1C, "hold"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h20,       1, 32'h18,       32'h1C, "unfreeze"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h20,       1, 32'h20,       1, 32'hDEAD_BEEF,32'h20, "skid_out"));
        vecs.push_back(mk(1,1,1,32'h4,       32'h100,0, 32'h0,        1, 32'h24,       1, 32'h20,       32'h24, "br_frozen"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'h24,       1, 32'h20,       32'h24, "br_ignored"));
        vecs.push_back(mk(1,0,1,32'h0,       32'h80, 0, 32'h0,        1, 32'h24,       0, 32'h0,        32'h24, "br_drain2"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'h24,       0, 32'h0,        32'h24, "drain2"));
        vecs.push_back(mk(0,0,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h40,       0, 32'h0,        32'h0,  "rst_mid"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        0, 32'h40,       0, 32'h0,        32'h0,  "idle2"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'h40,       1, 32'h40,       0, 32'h0,        32'h0,  "restart"));
        vecs.push_back(mk(1,0,1,32'hFFFF_FFFF,32'h0, 1, 32'h44,       1, 32'h44,       1, 32'h40,       32'h44, "br_wrap"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  1, 32'hAAAA_5555,1, 32'hFFFF_FFFC,0, 32'h0,        32'h44, "pc_max"));
        vecs.push_back(mk(1,0,0,32'h0,       32'h0,  0, 32'h0,        1, 32'h0,        1, 32'hAAAA_5555,32'h0,  "pc_wrap"));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].frz, vecs[i].br, vecs[i].off, vecs[i].idpc,
                  vecs[i].ack, vecs[i].rdata);
            #1;
            check(vecs[i].name, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                  vecs[i].e_instr, vecs[i].e_pco);
            step;
        end

        // Branch taken while the skid buffer is full: skid contents must be lost.
        drive(1, 1, 0, 32'h0, 32'h0, 1, 32'h0000_1234);
        #1;
        check("hold_br_pre", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        step;
        drive(1, 0, 1, 32'h1, 32'h200, 0, 32'h0);
        #1;
        check("hold_br", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
        step;
        drive(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        cnt = 0;
        while (!imem_req && cnt < 8) begin
            step;
            #1;
            cnt++;
        end
        if (!imem_req) begin
            n_vec++;
            n_err++;
            $display("FAIL hold_br_timeout: req=%0b after %0d cycles, want req=1", imem_req, cnt);
        end
        check("hold_br_tgt", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_5555;
        step;
        drive(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        check("after_hold_br", 1'b1, 32'h208, 1'b1, 32'h0000_5555, 32'h208);
        step;

`ifdef FETCH_PERF_CNT_EN
        drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        n_vec++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_reset: got stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
        end else begin
            $display("ok   cnt_reset: stall=%0d flush=%0d", stall_cnt, flush_cnt);
        end
        step;
        drive(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        step;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 32'h0, 32'h300, 1, 32'h0);
            step;
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 32'h0, 32'h0, 1, 32'h0);
            step;
        end
        drive(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        #1;
        n_vec++;
        if (stall_cnt !== 32'd5 || flush_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL perf_cnt: got stall=%0d flush=%0d, want 5 3", stall_cnt, flush_cnt);
        end else begin
            $display("ok   perf_cnt: stall=%0d flush=%0d", stall_cnt, flush_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage feeding the decode stage: owns the program counter, drives a request/acknowledge instruction-memory port, and holds the IF/ID pipeline register whose `instruction` and `pc_out` outputs the decode stage consumes. It redirects on a taken branch reported by decode, flushes the fetched slot to a NOP bubble, and stalls cleanly on a hazard freeze. A one-entry skid buffer catches an instruction that returns while the pipeline is frozen.

## Interface
- `RESET_PC`, default 32'h0000_0000. PC value after reset.
- `clk`  in  1  single pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  hazard stall from the hazard unit; holds PC, IF/ID register and branch handling.
- `br_taken`  in  1  taken branch in decode this cycle.
- `br_offset`  in  32  sign-extended word offset of the branch in decode.
- `id_pc`  in  32  PC+4 of the instruction currently in decode.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  fetch byte address; stable while `imem_req` is high.
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `valid`  out  1  IF/ID register holds a real instruction.
- `instruction`  out  32  IF/ID instruction word; NOP (32'h0) when not valid.
- `pc_out`  out  32  IF/ID PC+4 of `instruction`.

## Operation
- States: IDLE (reset only), FETCH (req=1), DRAIN (req=1, result discarded), HOLD (req=0, skid full).
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH, ack=1, freeze=0, no branch: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
- FETCH, ack=1, freeze=1: skid <= {rdata, pc+4}; pc <= pc+4; -> HOLD; IF/ID unchanged.
- FETCH, ack=0: the request persists regardless of freeze; IF/ID holds if freeze=1. If freeze=0, IF/ID loads a bubble (valid=0, instruction=0).
- HOLD, freeze=0, no branch: IF/ID <= skid; -> FETCH.
- Branch accepted only when `br_taken`=1 and `freeze`=0; `br_taken` is ignored while frozen.
- On an accepted branch, target = `id_pc` + (`br_offset` << 2), modulo 2^32. The PC is set to target, IF/ID is set to the bubble, and the skid is cleared.
- Branch next state:
  - FETCH with ack=1: the returned data is dropped; -> FETCH at target.
  - FETCH with ack=0: -> DRAIN.
  - HOLD: -> FETCH.
- DRAIN: keep the stale address until ack. Discard the data, then -> FETCH at target.
- A branch arriving in DRAIN re-targets the PC and stays in DRAIN.
- `imem_addr` = pc in FETCH, and the stale latched address in DRAIN.
- PC wraps modulo 2^32 with no error indication.

## Timing
- Reset (async assert) values:
  - state=IDLE, pc=RESET_PC, imem_req=0.
  - valid=0, instruction=0, pc_out=0, skid empty.
- First request appears on the first cycle after the first clock edge following reset release.
- With zero-wait memory (ack in the request cycle), throughput is 1 instruction/cycle and latency from request to IF/ID valid is 1 cycle.
- A taken branch in cycle n puts the bubble in IF/ID at n+1 and the request for the target in cycle n+1 (if not draining).
- `imem_req`/`imem_addr` are registered-state outputs; there is no combinational path from `imem_ack` to `imem_req`.
- `freeze` and `br_taken` take effect at the next clock edge.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `stall_cnt` (32, counts cycles with freeze=1 or imem_req=1 && imem_ack=0) and `flush_cnt` (32, counts accepted branches).
  - Both counters reset to 0 and wrap silently.
- `FETCH_PERF_CNT_EN` undefined: the counter ports and logic are absent; functional behaviour is identical.

## Structure
- The shared package `mips_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - The fetch-state enum {IDLE, FETCH, DRAIN, HOLD}.
  - `INSTR_W` = 32.
- One sub-module, `fetch_skid_buf`: a one-entry {instruction, pc} register with load/clear/full. Everything else lives in `if_fetch_unit`.

## Test plan
- Reset with RESET_PC=32'h40, then zero-wait memory returning rdata=addr -> `imem_addr` sequence 40, 44, 48; `pc_out` 44, 48, 4C with valid=1 from the second post-reset cycle.
- Memory with 2-cycle ack delay -> `imem_addr` stays 0x8 for 3 cycles; IF/ID carries bubbles until ack, then instruction from 0x8 with pc_out=0xC.
- Taken branch with id_pc=0x20, br_offset=-2 while a request is outstanding and unacked:
  - DRAIN keeps the old address until ack and drops that data.
  - The next request is to 0x18; IF/ID shows a bubble throughout.
- freeze=1 arriving the same cycle ack returns 0xDEAD_BEEF:
  - IF/ID holds its prior value and the FSM enters HOLD with req=0.
  - When freeze drops, IF/ID = 0xDEAD_BEEF, then fetching resumes.
- Raising br_taken and freeze together -> the branch is ignored; PC and IF/ID are unchanged.
- Asserting rst mid-DRAIN -> all outputs return to their reset values immediately, and fetch restarts at RESET_PC.
- With `FETCH_PERF_CNT_EN`, 3 branches and 5 frozen cycles -> flush_cnt=3, stall_cnt=5.
